// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles big-endian words into instruction memory, holding the CPU in reset until done.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps

module imem_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [32:0] CAPACITY = 33'((64'd1 << ADDR_W) - 64'(BASE_ADDR));

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CHK, S_DONE, S_ERR} state_e;
  localparam state_e S_AFTER_DATA = S_CHK;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_ERR} state_e;
  localparam state_e S_AFTER_DATA = S_DONE;
`endif

  state_e            state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       word_q, word_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       rem_q, rem_d;
  logic [7:0]        chk_q, chk_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              hold_q, hold_d;

  logic        accept;
  logic        start_ok;
  logic [31:0] assembled;

  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    word_d      = word_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    chk_d       = chk_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    error_d     = error_q;
    hold_d      = hold_q;

    in_ready  = (state_q == S_HDR) || (state_q == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                || (state_q == S_CHK)
`endif
                ;
    accept    = in_valid && in_ready;
    start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    assembled = {word_q, in_data};

    // Status flags trail the state by one edge so the last write lands before cpu_hold drops.
    if (start_ok) begin
      done_d  = 1'b0;
      error_d = 1'b0;
      hold_d  = 1'b1;
    end else if (state_q == S_DONE) begin
      done_d = 1'b1;
      hold_d = 1'b0;
    end else if (state_q == S_ERR) begin
      error_d = 1'b1;
    end

    case (state_q)
      S_HDR: begin
        if (accept) begin
          word_d = assembled[23:0];
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if ({1'b0, assembled} > CAPACITY) begin
              state_d = S_ERR;
            end else if (assembled == '0) begin
              state_d = S_AFTER_DATA;
            end else begin
              rem_d   = assembled;
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = assembled[23:0];
          chk_d  = chk_q ^ in_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = assembled;
            mem_addr_d  = ADDR_W'(BASE_ADDR) + idx_q;
            idx_d       = idx_q + 1'b1;
            rem_d       = rem_q - 32'd1;
            if (rem_q == 32'd1) state_d = S_AFTER_DATA;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) state_d = (in_data == chk_q) ? S_DONE : S_ERR;
      end
`endif
      default: begin
        if (start_ok) begin
          state_d = S_HDR;
          bcnt_d  = '0;
          word_d  = '0;
          idx_d   = '0;
          chk_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      bcnt_q      <= '0;
      word_q      <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      chk_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      hold_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      chk_q       <= chk_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
      hold_q      <= hold_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cpu_hold  = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=10, BASE_ADDR=0x10); adapts to IMEM_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps

module tb_imem_loader;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned BASE   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned maxgap);
    int unsigned g;
    g = $urandom_range(maxgap, 0);
    repeat (g) tick();
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned maxgap);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], maxgap);
  endtask

  task automatic finish_load(input logic [7:0] cs);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs, 0);
`else
    cs = cs;
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error} !== {2'b00, 10'd0, 32'd0, 3'b100}) begin
      n_fail++;
      $display("FAIL reset_values got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b want 0 0 000 00000000 1 0 0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
    end
  endtask

  task automatic test_two_words();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    n_checks++;
    if ({in_ready, cpu_hold} !== 2'b11) begin
      n_fail++; $display("FAIL start_enters_hdr got rdy=%b hold=%b want 1 1", in_ready, cpu_hold);
    end
    send_word(32'h0000_0002, 0);
    send_word(32'h2001_0005, 2);
    send_word(32'h8C02_0000, 2);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hAA, 1);
    n_checks++;
    if ({mem_we, done, cpu_hold} !== 3'b001) begin
      n_fail++; $display("FAIL chk_edge got we=%b done=%b hold=%b want 0 0 1", mem_we, done, cpu_hold);
    end
`else
    n_checks++;
    if ({mem_we, mem_addr, done, cpu_hold, in_ready} !== {1'b1, 10'h011, 3'b010}) begin
      n_fail++; $display("FAIL last_write_edge got we=%b addr=%h done=%b hold=%b rdy=%b want 1 011 0 1 0",
                         mem_we, mem_addr, done, cpu_hold, in_ready);
    end
`endif
    tick();
    n_checks++;
    if ({done, cpu_hold, in_ready, error} !== 4'b1000) begin
      n_fail++; $display("FAIL done_rise got done=%b hold=%b rdy=%b err=%b want 1 0 0 0", done, cpu_hold, in_ready, error);
    end
    n_checks++;
    if (wr_data.size() !== 2) begin
      n_fail++; $display("FAIL two_word_count got %0d want 2", wr_data.size());
    end
    n_checks++;
    if ({wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]} !== {10'h010, 32'h2001_0005, 10'h011, 32'h8C02_0000}) begin
      n_fail++; $display("FAIL two_word_data got %h:%h %h:%h want 010:20010005 011:8c020000",
                         wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
  endtask

  task automatic test_oversize();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    n_checks++;
    if ({done, cpu_hold, in_ready} !== 3'b011) begin
      n_fail++; $display("FAIL start_clears_done got done=%b hold=%b rdy=%b want 0 1 1", done, cpu_hold, in_ready);
    end
    send_word(32'h0000_03F1, 0);
    n_checks++;
    if ({error, in_ready} !== 2'b00) begin
      n_fail++; $display("FAIL oversize_edge got err=%b rdy=%b want 0 0", error, in_ready);
    end
    tick();
    n_checks++;
    if ({error, cpu_hold, done, in_ready} !== 4'b1100) begin
      n_fail++; $display("FAIL oversize_err got err=%b hold=%b done=%b rdy=%b want 1 1 0 0", error, cpu_hold, done, in_ready);
    end
    repeat (3) tick();
    n_checks++;
    if ({error, wr_data.size()} !== {1'b1, 32'd0}) begin
      n_fail++; $display("FAIL oversize_sticky got err=%b writes=%0d want 1 0", error, wr_data.size());
    end
  endtask

  task automatic test_bad_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_word(32'h2001_0005, 0);
    send_word(32'h8C02_0000, 0);
    send_byte(8'hAB, 0);
    tick();
    n_checks++;
    if ({error, done, cpu_hold, wr_data.size()} !== {3'b101, 32'd2}) begin
      n_fail++; $display("FAIL bad_checksum got err=%b done=%b hold=%b writes=%0d want 1 0 1 2",
                         error, done, cpu_hold, wr_data.size());
    end
`endif
  endtask

  task automatic test_single_gaps();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    n_checks++;
    if ({error, cpu_hold} !== 2'b01) begin
      n_fail++; $display("FAIL start_clears_error got err=%b hold=%b want 0 1", error, cpu_hold);
    end
    send_word(32'h0000_0001, 3);
    send_word(32'h1234_5678, 3);
    finish_load(8'h08);
`ifndef IMEM_LOADER_CHECKSUM_EN
    n_checks++;
    if ({mem_we, done} !== 2'b10) begin
      n_fail++; $display("FAIL gap_write_pulse got we=%b done=%b want 1 0", mem_we, done);
    end
`endif
    tick();
    n_checks++;
    if ({mem_we, done, cpu_hold} !== 3'b010) begin
      n_fail++; $display("FAIL gap_done got we=%b done=%b hold=%b want 0 1 0", mem_we, done, cpu_hold);
    end
    n_checks++;
    if ({wr_data.size(), wr_addr[0], wr_data[0]} !== {32'd1, 10'h010, 32'h1234_5678}) begin
      n_fail++; $display("FAIL gap_write got n=%0d %h:%h want 1 010:12345678", wr_data.size(), wr_addr[0], wr_data[0]);
    end
  endtask

  task automatic test_boundary_size();
    pulse_start();
    send_word(32'h0000_03F0, 0);
    repeat (2) tick();
    n_checks++;
    if ({in_ready, error} !== 2'b10) begin
      n_fail++; $display("FAIL max_count_accepted got rdy=%b err=%b want 1 0", in_ready, error);
    end
  endtask

  task automatic test_reset_abort();
    apply_reset();
    pulse_start();
    send_word(32'h0000_0003, 0);
    wr_addr.delete(); wr_data.delete();
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst = 1'b0;
    #2;
    n_checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error} !== {2'b00, 10'd0, 32'd0, 3'b100}) begin
      n_fail++; $display("FAIL async_reset got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b want 0 0 000 00000000 1 0 0",
                         in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
    end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    pulse_start();
    send_word(32'h0000_0001, 1);
    send_word(32'hDEAD_BEEF, 1);
    finish_load(8'h22);
    tick();
    n_checks++;
    if ({done, wr_data.size(), wr_addr[0], wr_data[0]} !== {1'b1, 32'd1, 10'h010, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL reload_after_abort got done=%b n=%0d %h:%h want 1 1 010:deadbeef",
                         done, wr_data.size(), wr_addr[0], wr_data[0]);
    end
  endtask

  task automatic test_start_ignored();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_word(32'h0000_0001, 0);
    send_byte(8'h00, 0);
    pulse_start();
    n_checks++;
    if ({in_ready, cpu_hold, wr_data.size()} !== {2'b11, 32'd1}) begin
      n_fail++; $display("FAIL start_in_data got rdy=%b hold=%b writes=%0d want 1 1 1", in_ready, cpu_hold, wr_data.size());
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    finish_load(8'h03);
    tick();
    n_checks++;
    if ({done, wr_data.size(), wr_addr[1], wr_data[1]} !== {1'b1, 32'd2, 10'h011, 32'h0000_0002}) begin
      n_fail++; $display("FAIL start_ignored_index got done=%b n=%0d %h:%h want 1 2 011:00000002",
                         done, wr_data.size(), wr_addr[1], wr_data[1]);
    end
  endtask

  task automatic test_zero_count();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_word(32'h0000_0000, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    n_checks++;
    if ({in_ready, done} !== 2'b10) begin
      n_fail++; $display("FAIL zero_to_chk got rdy=%b done=%b want 1 0", in_ready, done);
    end
    send_byte(8'h00, 0);
`else
    n_checks++;
    if ({in_ready, done} !== 2'b00) begin
      n_fail++; $display("FAIL zero_to_done got rdy=%b done=%b want 0 0", in_ready, done);
    end
`endif
    tick();
    n_checks++;
    if ({done, cpu_hold, error, wr_data.size()} !== {3'b100, 32'd0}) begin
      n_fail++; $display("FAIL zero_done got done=%b hold=%b err=%b writes=%0d want 1 0 0 0",
                         done, cpu_hold, error, wr_data.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    test_reset();
    test_two_words();
    test_oversize();
    test_bad_checksum();
    test_single_gaps();
    test_boundary_size();
    test_reset_abort();
    test_start_ignored();
    test_zero_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
